// File: rtl/bin_to_bcd_digits.sv
// ============================================================================
// Module   : bin_to_bcd_digits
// Brief    : Iterative double-dabble binary-to-BCD converter that drives the
//            7-segment digit decoders (codes 0-9, 10 = minus, 11 = blank).
//            Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_digits #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [WIDTH-1:0]        value,
    output logic                    busy,
    output logic                    done,
    output logic [4*(DIGITS+1)-1:0] digits
);

    localparam int               CW         = $clog2(WIDTH + 1);
    localparam int               BW         = 4 * DIGITS;
    localparam logic [CW-1:0]    c_cnt_init = CW'(WIDTH);
    localparam logic [CW-1:0]    c_cnt_one  = CW'(1);
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
    localparam logic [3:0]       c_minus    = 4'd10;
    localparam logic [3:0]       c_blank    = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FORMAT = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [WIDTH-1:0]          r_mag;
    logic [BW-1:0]             r_bcd;
    logic [CW-1:0]             r_cnt;
    logic                      r_neg;
    logic                      r_done;
    logic [4*(DIGITS+1)-1:0]   r_digits;

    logic                      w_neg;
    logic [BW-1:0]             w_adj;
    logic [BW+WIDTH-1:0]       w_shift;
    logic [BW-1:0]             w_fmt;
    logic [3:0]                w_sign;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SHIFT;
            S_SHIFT:  if (r_cnt == c_cnt_one) w_next = S_FORMAT;
            S_FORMAT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_neg = (SIGNED != 0) ? value[WIDTH-1] : 1'b0;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                               : r_bcd[4*g +: 4];
        end
    endgenerate

    assign w_shift = {w_adj, r_mag} << 1;

`ifdef LEADING_ZERO_BLANK_EN
    logic w_lead;
`endif

    // Digit 0 is never blanked so a zero result still shows "0".
    always_comb begin
        w_fmt = r_bcd;
`ifdef LEADING_ZERO_BLANK_EN
        w_lead = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            if (w_lead && (r_bcd[4*k +: 4] == 4'd0)) w_fmt[4*k +: 4] = c_blank;
            else                                     w_lead = 1'b0;
        end
`endif
    end

    assign w_sign = (r_neg && (r_bcd != '0)) ? c_minus : c_blank;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mag    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_digits <= {(DIGITS+1){c_blank}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mag <= w_neg ? (~value + c_one) : value;
                        r_neg <= w_neg;
                        r_bcd <= '0;
                        r_cnt <= c_cnt_init;
                    end
                end
                S_SHIFT: begin
                    {r_bcd, r_mag} <= w_shift;
                    r_cnt          <= r_cnt - c_cnt_one;
                end
                S_FORMAT: begin
                    r_digits <= {w_sign, w_fmt};
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign digits = r_digits;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_digits.sv
// ============================================================================
// Module   : tb_bin_to_bcd_digits
// Brief    : Self-checking bench for bin_to_bcd_digits (signed and unsigned).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_digits;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_s = 1'b0;
    logic        start_u = 1'b0;
    logic [15:0] value_s = '0;
    logic [15:0] value_u = '0;
    logic        busy_s, done_s, busy_u, done_u;
    logic [23:0] dig_s, dig_u;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    bin_to_bcd_digits #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) u_dut_s (
        .clock(clock), .reset_n(reset_n), .start(start_s), .value(value_s),
        .busy(busy_s), .done(done_s), .digits(dig_s)
    );

    bin_to_bcd_digits #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_dut_u (
        .clock(clock), .reset_n(reset_n), .start(start_u), .value(value_u),
        .busy(busy_u), .done(done_u), .digits(dig_u)
    );

    typedef struct {
        bit          uns;
        logic [15:0] val;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One conversion: latency, busy, digit stability, result, single-cycle done.
    task automatic run(input bit uns, input logic [15:0] v, input logic [23:0] exp, input string name);
        logic [23:0] prev;
        int          cyc;
        bit          busy_ok;
        bit          stable_ok;
        @(negedge clock);
        if (uns) begin value_u = v; start_u = 1'b1; end
        else     begin value_s = v; start_s = 1'b1; end
        prev = uns ? dig_u : dig_s;
        @(posedge clock); #1;
        start_s = 1'b0; start_u = 1'b0;
        cyc = 0; busy_ok = 1'b1; stable_ok = 1'b1;
        while (!(uns ? done_u : done_s) && cyc < 40) begin
            if (!(uns ? busy_u : busy_s)) busy_ok = 1'b0;
            if ((uns ? dig_u : dig_s) !== prev) stable_ok = 1'b0;
            @(posedge clock); #1;
            cyc++;
        end
        chk({name, " latency"}, cyc, 17);
        chk({name, " busy held"}, {31'd0, busy_ok}, 1);
        chk({name, " digits stable"}, {31'd0, stable_ok}, 1);
        chk({name, " digits"}, {8'd0, (uns ? dig_u : dig_s)}, {8'd0, exp});
        chk({name, " busy at done"}, {31'd0, (uns ? busy_u : busy_s)}, 0);
        @(posedge clock); #1;
        chk({name, " done pulse width"}, {31'd0, (uns ? done_u : done_s)}, 0);
    endtask

    initial begin
        logic [23:0] first_dig;
        int          cyc;
        int          n_done;
        int          first_cyc;

        tbl[0]  = '{1'b0, 16'd1234,  LZB ? 24'hBB1234 : 24'hB01234};
        tbl[1]  = '{1'b0, 16'h8000,  24'hA32768};
        tbl[2]  = '{1'b0, 16'hFFFF,  LZB ? 24'hABBBB1 : 24'hA00001};
        tbl[3]  = '{1'b0, 16'h0000,  LZB ? 24'hBBBBB0 : 24'hB00000};
        tbl[4]  = '{1'b0, 16'd42,    LZB ? 24'hBBBB42 : 24'hB00042};
        tbl[5]  = '{1'b0, 16'h7FFF,  24'hB32767};
        tbl[6]  = '{1'b0, 16'hFF9C,  LZB ? 24'hABB100 : 24'hA00100};
        tbl[7]  = '{1'b0, 16'd10000, 24'hB10000};
        tbl[8]  = '{1'b0, 16'd9,     LZB ? 24'hBBBBB9 : 24'hB00009};
        tbl[9]  = '{1'b1, 16'hFFFF,  24'hB65535};
        tbl[10] = '{1'b1, 16'h8000,  24'hB32768};
        tbl[11] = '{1'b1, 16'h0000,  LZB ? 24'hBBBBB0 : 24'hB00000};

        repeat (3) @(posedge clock);
        #1;
        chk("reset busy_s", {31'd0, busy_s}, 0);
        chk("reset done_s", {31'd0, done_s}, 0);
        chk("reset dig_s", {8'd0, dig_s}, 32'h00BBBBBB);
        chk("reset dig_u", {8'd0, dig_u}, 32'h00BBBBBB);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run(tbl[i].uns, tbl[i].val, tbl[i].exp, $sformatf("vec%0d", i));

        // Start pulsed mid-conversion is ignored; value changes after capture too.
        @(negedge clock);
        value_s = 16'd1234; start_s = 1'b1;
        @(posedge clock); #1;
        start_s = 1'b0; cyc = 0;
        repeat (5) begin @(posedge clock); #1; cyc++; end
        @(negedge clock);
        value_s = 16'd9999; start_s = 1'b1;
        @(posedge clock); #1;
        start_s = 1'b0; value_s = 16'h2222; cyc++;
        n_done = 0; first_cyc = 0; first_dig = '0;
        while (cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            if (done_s) begin
                n_done++;
                if (n_done == 1) begin first_cyc = cyc; first_dig = dig_s; end
            end
        end
        chk("ignore-start done count", n_done, 1);
        chk("ignore-start latency", first_cyc, 17);
        chk("ignore-start digits", {8'd0, first_dig}, {8'd0, LZB ? 24'hBB1234 : 24'hB01234});

        // Start asserted in the done cycle is accepted.
        @(negedge clock);
        value_s = 16'd1234; start_s = 1'b1;
        @(posedge clock); #1;
        start_s = 1'b0; cyc = 0;
        while (!done_s && cyc < 40) begin @(posedge clock); #1; cyc++; end
        chk("b2b first latency", cyc, 17);
        value_s = 16'd42; start_s = 1'b1;
        @(posedge clock); #1;
        start_s = 1'b0;
        chk("b2b accepted busy", {31'd0, busy_s}, 1);
        cyc = 0;
        while (!done_s && cyc < 40) begin @(posedge clock); #1; cyc++; end
        chk("b2b second latency", cyc, 17);
        chk("b2b second digits", {8'd0, dig_s}, {8'd0, LZB ? 24'hBBBB42 : 24'hB00042});

        // Asynchronous reset during SHIFT aborts with no done.
        @(posedge clock); #1;
        @(negedge clock);
        value_s = 16'd1234; start_s = 1'b1;
        @(posedge clock); #1;
        start_s = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy_s}, 0);
        chk("abort done", {31'd0, done_s}, 0);
        chk("abort digits", {8'd0, dig_s}, 32'h00BBBBBB);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        n_done = 0;
        repeat (25) begin @(posedge clock); #1; if (done_s) n_done++; end
        chk("abort no done", n_done, 0);
        run(1'b0, 16'd42, LZB ? 24'hBBBB42 : 24'hB00042, "post-abort 42");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
